// File: rtl/pc_gen.sv
// pc_gen: front-end program counter with prioritised redirects, boot/halt FSM
// Optional misaligned-target detection under PC_MISALIGN_CHK_EN
module pc_gen #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RST_ADDR   = '0,
  parameter int              INST_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            boot_en,
  input  logic            halt_req,
  input  logic            trap_flag,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            flush_flag,
  input  logic [XLEN-1:0] flush_addr,
  input  logic            bj_flag,
  input  logic [XLEN-1:0] bj_addr,
  input  logic            pipe_stall,
  input  logic            iram_ready,
  output logic            iram_en,
  output logic [XLEN-1:0] pc_o,
  output logic            redirect_o,
  output logic [1:0]      state_o
`ifdef PC_MISALIGN_CHK_EN
  ,
  output logic            misalign_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] STEP =
    XLEN'(INST_BYTES);

  state_t          state_q;
  state_t          state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            redir_q;
  logic            redir_d;
  logic            fetch_blk;
  logic            accept;
  logic            sel_trap;
  logic            sel_flush;
  logic            sel_bj;
  logic            sel_inc;
  logic            any_redir;
  logic [XLEN-1:0] tgt;

`ifdef PC_MISALIGN_CHK_EN
  localparam bit CHK_B1 = (INST_BYTES == 4);

  logic mis_q;
  logic mis_d;
  logic tgt_bad;

  assign tgt_bad   = tgt[0] | (CHK_B1 & tgt[1]);
  assign fetch_blk = mis_q;
  assign misalign_o = mis_q;
`else
  assign fetch_blk = 1'b0;
`endif

  // fetch request is live only while running, unstalled and out of reset
  always_comb begin
    iram_en = 1'b0;
    if (rst_n && state_q == RUN
        && !pipe_stall && !fetch_blk)
      iram_en = 1'b1;
  end

  assign accept = iram_en & iram_ready;

  // redirect source selection: trap wakes HALT, others only act in RUN
  always_comb begin
    sel_trap  = 1'b0;
    sel_flush = 1'b0;
    sel_bj    = 1'b0;
    unique case (state_q)
      RUN: begin
        sel_trap  = trap_flag;
        sel_flush = !trap_flag && flush_flag;
        sel_bj    = !trap_flag && !flush_flag
                    && bj_flag;
      end
      HALT: sel_trap = trap_flag;
      default: ;
    endcase
  end

  assign any_redir = sel_trap | sel_flush | sel_bj;
  assign sel_inc   = accept & ~any_redir;

  // chosen redirect target, zero when nothing redirects
  always_comb begin
    tgt = '0;
    unique case (1'b1)
      sel_trap:  tgt = trap_addr;
      sel_flush: tgt = flush_addr;
      sel_bj:    tgt = bj_addr;
      default:   tgt = '0;
    endcase
  end

  // next PC: redirect beats increment beats hold; increment wraps
  always_comb begin
    pc_d    = pc_q;
    redir_d = 1'b0;
    unique case (1'b1)
      any_redir: begin
        pc_d    = tgt;
        redir_d = 1'b1;
      end
      sel_inc:  pc_d = pc_q + STEP;
      default:  pc_d = pc_q;
    endcase
  end

`ifdef PC_MISALIGN_CHK_EN
  // misalign flag follows the alignment of the most recent redirect
  always_comb begin
    mis_d = mis_q;
    if (any_redir)
      mis_d = tgt_bad;
  end
`endif

  // fetch FSM next state; the spare encoding falls back to IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (boot_en)
          state_d = RUN;
      end
      RUN: begin
        if (halt_req && !trap_flag)
          state_d = HALT;
      end
      HALT: begin
        if (!halt_req || trap_flag)
          state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // architectural state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RST_ADDR;
      redir_q <= 1'b0;
`ifdef PC_MISALIGN_CHK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
`ifdef PC_MISALIGN_CHK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign pc_o       = pc_q;
  assign redirect_o = redir_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed plan steps plus random traffic vs a behavioural model
// Covers the optional misalign output when PC_MISALIGN_CHK_EN is defined
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        boot_en;
  logic        halt_req;
  logic        trap_flag;
  logic [31:0] trap_addr;
  logic        flush_flag;
  logic [31:0] flush_addr;
  logic        bj_flag;
  logic [31:0] bj_addr;
  logic        pipe_stall;
  logic        iram_ready;
  logic        iram_en;
  logic [31:0] pc_o;
  logic        redirect_o;
  logic [1:0]  state_o;
`ifdef PC_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  always #5 clk = ~clk;

  pc_gen #(
    .XLEN(32),
    .RST_ADDR(32'h0000_0000),
    .INST_BYTES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .boot_en(boot_en),
    .halt_req(halt_req),
    .trap_flag(trap_flag),
    .trap_addr(trap_addr),
    .flush_flag(flush_flag),
    .flush_addr(flush_addr),
    .bj_flag(bj_flag),
    .bj_addr(bj_addr),
    .pipe_stall(pipe_stall),
    .iram_ready(iram_ready),
    .iram_en(iram_en),
    .pc_o(pc_o),
    .redirect_o(redirect_o),
    .state_o(state_o)
`ifdef PC_MISALIGN_CHK_EN
    ,
    .misalign_o(misalign_o)
`endif
  );

  int errors = 0;
  int checks = 0;

  // reference model: 0 idle, 1 run, 2 halt
  logic [31:0] m_pc;
  int          m_st;
  logic        m_rd;
  logic        m_mis;
  bit          m_valid = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic m_en();
    return rst_n && m_st == 1
           && !pipe_stall && !m_mis;
  endfunction

  task automatic m_load(input logic [31:0] a);
    m_pc = a;
    m_rd = 1'b1;
`ifdef PC_MISALIGN_CHK_EN
    m_mis = (a % 4) != 0;
`endif
  endtask

  task automatic m_edge();
    bit acc;
    acc  = m_en() && iram_ready;
    m_rd = 1'b0;
    if (!rst_n) begin
      m_pc    = 32'h0;
      m_st    = 0;
      m_mis   = 1'b0;
      m_valid = 1;
    end else if (m_valid) begin
      if (m_st == 0) begin
        if (boot_en) m_st = 1;
      end else if (m_st == 1) begin
        if (trap_flag)       m_load(trap_addr);
        else if (flush_flag) m_load(flush_addr);
        else if (bj_flag)    m_load(bj_addr);
        else if (acc)        m_pc = m_pc + 32'd4;
        if (halt_req && !trap_flag) m_st = 2;
      end else begin
        if (trap_flag) begin
          m_load(trap_addr);
          m_st = 1;
        end else if (!halt_req) begin
          m_st = 1;
        end
      end
    end
  endtask

  task automatic step();
    #1;
    if (m_valid) chk("iram_en", 32'(iram_en), 32'(m_en()));
    @(posedge clk);
    m_edge();
    #1;
    if (m_valid) begin
      chk("pc_o", pc_o, m_pc);
      chk("state_o", 32'(state_o), 32'(m_st));
      chk("redirect_o", 32'(redirect_o), 32'(m_rd));
`ifdef PC_MISALIGN_CHK_EN
      chk("misalign_o", 32'(misalign_o), 32'(m_mis));
`endif
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    boot_en    = 1'b0;
    halt_req   = 1'b0;
    trap_flag  = 1'b0;
    trap_addr  = '0;
    flush_flag = 1'b0;
    flush_addr = '0;
    bj_flag    = 1'b0;
    bj_addr    = '0;
    pipe_stall = 1'b0;
    iram_ready = 1'b1;

    // reset for two cycles
    step();
    step();
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_redir", 32'(redirect_o), 32'd0);
    chk("rst_en", 32'(iram_en), 32'd0);

    // boot and sequential fetch
    rst_n   = 1'b1;
    boot_en = 1'b1;
    step();
    chk("boot_state", 32'(state_o), 32'd1);
    chk("boot_pc0", pc_o, 32'h0);
    boot_en = 1'b0;
    step();
    chk("boot_pc4", pc_o, 32'h4);
    step();
    chk("boot_pc8", pc_o, 32'h8);
    step();
    step();
    chk("seq_pc10", pc_o, 32'h10);

    // stall two cycles, then one un-ready cycle
    pipe_stall = 1'b1;
    #1 chk("stall_en", 32'(iram_en), 32'd0);
    step();
    chk("stall_hold1", pc_o, 32'h10);
    step();
    chk("stall_hold2", pc_o, 32'h10);
    pipe_stall = 1'b0;
    iram_ready = 1'b0;
    step();
    chk("nready_hold", pc_o, 32'h10);
    iram_ready = 1'b1;
    step();
    chk("resume_pc14", pc_o, 32'h14);

    // redirect priority
    trap_flag  = 1'b1;
    trap_addr  = 32'h100;
    flush_flag = 1'b1;
    flush_addr = 32'h200;
    bj_flag    = 1'b1;
    bj_addr    = 32'h300;
    step();
    chk("prio_trap", pc_o, 32'h100);
    chk("prio_redir", 32'(redirect_o), 32'd1);
    trap_flag  = 1'b0;
    flush_flag = 1'b0;
    bj_flag    = 1'b0;
    step();
    chk("redir_pulse", 32'(redirect_o), 32'd0);
    chk("post_redir_pc", pc_o, 32'h104);
    flush_flag = 1'b1;
    bj_flag    = 1'b1;
    step();
    chk("prio_flush", pc_o, 32'h200);
    flush_flag = 1'b0;
    bj_flag    = 1'b0;

    // halt at 0x40, ignore bj, wake on trap
    bj_flag    = 1'b1;
    bj_addr    = 32'h40;
    iram_ready = 1'b0;
    step();
    bj_flag  = 1'b0;
    halt_req = 1'b1;
    step();
    chk("halt_state", 32'(state_o), 32'd2);
    chk("halt_pc", pc_o, 32'h40);
    bj_flag = 1'b1;
    bj_addr = 32'h80;
    step();
    chk("halt_bj_ign", pc_o, 32'h40);
    chk("halt_en", 32'(iram_en), 32'd0);
    bj_flag   = 1'b0;
    trap_flag = 1'b1;
    trap_addr = 32'h1C0;
    step();
    chk("wake_state", 32'(state_o), 32'd1);
    chk("wake_pc", pc_o, 32'h1C0);
    trap_flag  = 1'b0;
    halt_req   = 1'b0;
    iram_ready = 1'b1;

    // wrap at top of address space
    bj_flag = 1'b1;
    bj_addr = 32'hFFFF_FFFC;
    step();
    bj_flag = 1'b0;
    step();
    chk("wrap_pc", pc_o, 32'h0);

`ifdef PC_MISALIGN_CHK_EN
    // misaligned target blocks fetch until aligned trap
    bj_flag = 1'b1;
    bj_addr = 32'h102;
    step();
    bj_flag = 1'b0;
    chk("mis_pc", pc_o, 32'h102);
    chk("mis_set", 32'(misalign_o), 32'd1);
    step();
    chk("mis_hold", pc_o, 32'h102);
    chk("mis_en", 32'(iram_en), 32'd0);
    trap_flag = 1'b1;
    trap_addr = 32'h100;
    step();
    trap_flag = 1'b0;
    chk("mis_clr", 32'(misalign_o), 32'd0);
    chk("mis_resume", 32'(iram_en), 32'd1);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst_n      = ($urandom_range(49) != 0);
      boot_en    = ($urandom_range(1) == 1);
      halt_req   = ($urandom_range(7) == 0);
      trap_flag  = ($urandom_range(15) == 0);
      flush_flag = ($urandom_range(7) == 0);
      bj_flag    = ($urandom_range(5) == 0);
      pipe_stall = ($urandom_range(3) == 0);
      iram_ready = ($urandom_range(3) != 0);
      trap_addr  = $urandom;
      flush_addr = $urandom;
      bj_addr    = $urandom;
      if ($urandom_range(3) != 0) begin
        trap_addr[1:0]  = 2'b00;
        flush_addr[1:0] = 2'b00;
        bj_addr[1:0]    = 2'b00;
      end
      step();
    end

    // reset overrides stall, halt and pending redirects
    rst_n      = 1'b0;
    trap_flag  = 1'b1;
    flush_flag = 1'b1;
    bj_flag    = 1'b1;
    halt_req   = 1'b1;
    pipe_stall = 1'b1;
    step();
    chk("midrst_pc", pc_o, 32'h0);
    chk("midrst_state", 32'(state_o), 32'd0);
    chk("midrst_redir", 32'(redirect_o), 32'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program-counter unit for the core front end; drives the instruction-RAM request address.
- Adds over the basic PC register: configurable width, reset address and step; prioritised multi-source redirect (trap, flush, branch/jump); iram ready handshake; boot and halt control.
- Sits between execute/commit redirect sources and the instruction RAM.

Parameters:
- XLEN, 32, PC and address width.
- RST_ADDR, 32'h0000_0000, pc_o value after reset (XLEN bits).
- INST_BYTES, 4, sequential increment in bytes; legal values are 2 and 4.

Ports:
- clk  input  1  core clock
- rst_n  input  1  reset, synchronous, active-low
- boot_en  input  1  level; leaves IDLE and starts fetching
- halt_req  input  1  level; request to stop fetching
- trap_flag  input  1  trap redirect strobe
- trap_addr  input  XLEN  trap target
- flush_flag  input  1  pipeline-flush redirect strobe
- flush_addr  input  XLEN  flush target
- bj_flag  input  1  branch/jump redirect strobe
- bj_addr  input  XLEN  branch/jump target
- pipe_stall  input  1  downstream stall; hold PC
- iram_ready  input  1  iram accepts the current request
- iram_en  output  1  fetch request valid
- pc_o  output  XLEN  registered fetch address
- redirect_o  output  1  registered; pc_o loaded from a redirect last edge
- state_o  output  2  current FSM state (IDLE=0, RUN=1, HALT=2)

Behaviour:
- One clock domain. Reset is synchronous, active-low, sampled on the clk rising edge: pc_o=RST_ADDR, state=IDLE, redirect_o=0. iram_en=0 while in reset and in IDLE.
- iram_en is combinational: 1 only when state==RUN and pipe_stall==0.
- A request is accepted when iram_en and iram_ready are both 1. The PC advances only on an accepted request.
- FSM:
  - IDLE -> RUN when boot_en=1. All redirects and halt_req are ignored in IDLE, and pc_o holds.
  - RUN -> HALT when halt_req=1 and no trap_flag is asserted that cycle. Flush and bj redirects still load pc_o on the transition edge.
  - HALT -> RUN when halt_req=0, or when trap_flag=1 (trap wakes the core regardless of halt_req). In HALT, flush_flag and bj_flag are ignored.
  - State 3 is unreachable; if entered, return to IDLE.
- next-PC priority in RUN, evaluated every cycle:
  1. trap_addr
  2. flush_addr
  3. bj_addr
  4. pc_o + INST_BYTES if a request is accepted
  5. otherwise hold pc_o
- Redirects override pipe_stall and an un-ready iram: the target is loaded regardless.
- Simultaneous strobes: the highest-priority strobe wins; lower ones are dropped, not queued.
- Arithmetic: the increment is modulo 2^XLEN. pc_o = 2^XLEN - INST_BYTES wraps to 0 with no flag.
- redirect_o = 1 for exactly one cycle following any edge where pc_o was loaded from trap/flush/bj; otherwise 0.
- Latency: a redirect strobe in cycle N makes pc_o = target in cycle N+1, with iram_en asserted in N+1 if RUN and not stalled.
- Reset asserted mid-operation (stall, HALT, pending redirect) overrides everything on the next edge.

Optional Feature:
- Macro PC_MISALIGN_CHK_EN.
- When defined:
  - Adds output misalign_o (1 bit, registered, reset 0).
  - When a redirect target has addr[0]=1, or addr[1:0]!=0 when INST_BYTES=4, pc_o still loads the target, misalign_o=1 the following cycle, and iram_en is forced 0 until the next redirect or reset.
  - A trap redirect to an aligned address clears misalign_o.
- When undefined: no misalign_o port, no check; targets are loaded unmodified.

Test Plan:
- Reset then boot: rst_n=0 two cycles, release, boot_en=1 at cycle 3, iram_ready=1 -> pc_o 0x0 in cycle 4, 0x4 in cycle 5, 0x8 in cycle 6; state_o 0->1.
- Stall and handshake: in RUN at pc_o=0x10, pipe_stall=1 for 2 cycles, then iram_ready=0 for 1 cycle -> pc_o holds 0x10 for 3 cycles, iram_en=0 during the stall, then advances to 0x14.
- Priority: trap_flag, flush_flag and bj_flag together with addrs 0x100/0x200/0x300 -> pc_o=0x100 next cycle, redirect_o=1 for one cycle; flush+bj only -> 0x200.
- Halt/wake: halt_req=1 at pc_o=0x40 -> state_o=2, iram_en=0, pc_o holds 0x40; bj_flag with 0x80 ignored; trap_flag with 0x1C0 -> state_o=1, pc_o=0x1C0.
- Wrap: XLEN=32, INST_BYTES=4, bj_addr=0xFFFF_FFFC then accepted fetch -> pc_o=0x0000_0000.
- PC_MISALIGN_CHK_EN defined: bj_addr=0x0000_0102 -> pc_o=0x102, misalign_o=1, iram_en=0; subsequent trap to 0x100 -> misalign_o=0, fetch resumes.
